// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, FSM state encodings and instruction classification
// used by the multi-cycle controller, PC register and ALU.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE,
    C_J, C_JAL, C_JR, C_HALT, C_NOP
  } instr_cls_t;

  // Anything not recognised (bad opcode or bad R-type funct) becomes a nop.
  function automatic instr_cls_t classify(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [5:0] halt_op);
    instr_cls_t c;
    c = C_NOP;
    if (op == halt_op) c = C_HALT;
    else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: c = C_RALU;
            FN_JR:   c = C_JR;
            default: c = C_NOP;
          endcase
        end
        OP_ADDI: c = C_ADDI;
        OP_ORI:  c = C_ORI;
        OP_LW:   c = C_LW;
        OP_SW:   c = C_SW;
        OP_BEQ:  c = C_BEQ;
        OP_BNE:  c = C_BNE;
        OP_J:    c = C_J;
        OP_JAL:  c = C_JAL;
        default: c = C_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multi-cycle controller and the datapath: instruction fields in,
// datapath strobes and selects out.
interface multicycle_ctrl_if #(parameter int ALUOP_W = 3);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               PCWre;
  logic [1:0]         PCSrc;
  logic               IRWre;
  logic               RegWre;
  logic [1:0]         RegDst;
  logic               WrRegDSrc;
  logic               ALUSrcB;
  logic               ExtSel;
  logic [ALUOP_W-1:0] ALUOp;
  logic               mRD;
  logic               mWR;
  logic               DBDataSrc;
  logic [2:0]         state;

  modport master (
    input  opcode, funct, zero,
    output PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ExtSel,
           ALUOp, mRD, mWR, DBDataSrc, state
  );

  modport slave (
    output opcode, funct, zero,
    input  PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ExtSel,
           ALUOp, mRD, mWR, DBDataSrc, state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps FSM state plus instruction fields and the ALU
// zero flag onto the datapath controls. Selects follow the instruction; writes follow state.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter int         ALUOP_W = 3,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  state_t             state,
  input  logic               halted,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc
);

  instr_cls_t cls;
  logic       br_taken;

  assign cls      = classify(opcode, funct, HALT_OP);
  assign br_taken = ((cls == C_BEQ) && zero) || ((cls == C_BNE) && !zero);

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PCSRC_PC4;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALUOP_W'(ALU_ADD);
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;

    // The IR still holds the previous instruction during fetch, so ignore it there.
    if (state == S_IF) begin
      IRWre = 1'b1;
    end else if (!halted && cls != C_HALT) begin
      ExtSel    = (cls != C_ORI);
      ALUSrcB   = (cls inside {C_ADDI, C_ORI, C_LW, C_SW});
      WrRegDSrc = (cls != C_JAL);
      DBDataSrc = (cls == C_LW);
      if (cls == C_RALU)     RegDst = 2'b01;
      else if (cls == C_JAL) RegDst = 2'b10;

      case (cls)
        C_RALU:       ALUOp = ALUOP_W'(funct_aluop(funct));
        C_ORI:        ALUOp = ALUOP_W'(ALU_OR);
        C_BEQ, C_BNE: ALUOp = ALUOP_W'(ALU_SUB);
        default:      ALUOp = ALUOP_W'(ALU_ADD);
      endcase

      case (state)
        S_ID: begin
          case (cls)
            C_J:   begin PCWre = 1'b1; PCSrc = PCSRC_JMP; end
            C_JAL: begin PCWre = 1'b1; PCSrc = PCSRC_JMP; RegWre = 1'b1; end
            C_JR:  begin PCWre = 1'b1; PCSrc = PCSRC_RS; end
            C_NOP: PCWre = 1'b1;
            default: ;
          endcase
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          if (br_taken) PCSrc = PCSRC_BR;
        end
        S_MEM: begin
          mRD   = (cls == C_LW);
          mWR   = (cls == C_SW);
          PCWre = (cls == C_SW);
        end
        S_WB_LD, S_WB_AL: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps each instruction through IF/ID/EXE/MEM/WB and
// parks in ID on the halt opcode until reset.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int         ALUOP_W = 3,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic              CLK,
  input logic              Reset,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       halt_q, halt_d;
  instr_cls_t cls;

  assign cls = classify(bus.opcode, bus.funct, HALT_OP);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (!halt_q) begin
          case (cls)
            C_RALU, C_ADDI, C_ORI: state_d = S_EXE_AL;
            C_BEQ, C_BNE:          state_d = S_EXE_BR;
            C_LW, C_SW:            state_d = S_EXE_LS;
            C_HALT:                halt_d  = 1'b1;
            default:               state_d = S_IF;
          endcase
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (cls == C_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  assign bus.state = state_q;

  ctrl_decode #(.ALUOP_W(ALUOP_W), .HALT_OP(HALT_OP)) u_decode (
    .state     (state_q),
    .halted    (halt_q),
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .zero      (bus.zero),
    .PCWre     (bus.PCWre),
    .PCSrc     (bus.PCSrc),
    .IRWre     (bus.IRWre),
    .RegWre    (bus.RegWre),
    .RegDst    (bus.RegDst),
    .WrRegDSrc (bus.WrRegDSrc),
    .ALUSrcB   (bus.ALUSrcB),
    .ExtSel    (bus.ExtSel),
    .ALUOp     (bus.ALUOp),
    .mRD       (bus.mRD),
    .mWR       (bus.mWR),
    .DBDataSrc (bus.DBDataSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction steps plus random instruction stream,
// checked per cycle against an instruction-level model of states and strobes.
module tb_multicycle_ctrl;

  logic CLK;
  logic Reset;
  int   tests;
  int   fails;

  multicycle_ctrl_if #(.ALUOP_W(3)) bus ();

  multicycle_ctrl #(.ALUOP_W(3), .HALT_OP(6'b111111)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction kinds: 0 add,1 sub,2 and,3 or,4 slt,5 addi,6 ori,7 lw,8 sw,
  // 9 beq,10 bne,11 j,12 jal,13 jr,14 bad opcode,15 bad funct.
  localparam int K_ADD = 0, K_SLT = 4, K_ADDI = 5, K_ORI = 6, K_LW = 7, K_SW = 8,
                 K_BEQ = 9, K_BNE = 10, K_J = 11, K_JAL = 12, K_JR = 13,
                 K_BADOP = 14, K_BADFN = 15;

  function automatic logic [5:0] kind_op(input int k);
    case (k)
      K_ADDI: return 6'b001000;
      K_ORI:  return 6'b001101;
      K_LW:   return 6'b100011;
      K_SW:   return 6'b101011;
      K_BEQ:  return 6'b000100;
      K_BNE:  return 6'b000101;
      K_J:    return 6'b000010;
      K_JAL:  return 6'b000011;
      K_BADOP: return 6'b010101;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] kind_fn(input int k, input logic [5:0] rnd);
    case (k)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      K_JR:    return 6'b001000;
      K_BADFN: return 6'b000001;
      default: return rnd;
    endcase
  endfunction

  function automatic int kind_len(input int k);
    if (k <= K_ORI || k == K_SW) return 4;
    if (k == K_LW) return 5;
    if (k == K_BEQ || k == K_BNE) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] kind_state(input int k, input int i);
    if (i == 0) return 3'd0;
    if (i == 1) return 3'd1;
    if (k <= K_ORI) return (i == 2) ? 3'd6 : 3'd7;
    if (k == K_LW || k == K_SW) return 3'(i);
    return 3'd5;
  endfunction

  function automatic logic kind_writes(input int k);
    return (k <= K_LW) || (k == K_JAL);
  endfunction

  function automatic logic [1:0] kind_regdst(input int k);
    if (k <= K_SLT) return 2'b01;
    if (k == K_JAL) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] kind_aluop(input int k);
    if (k <= K_SLT) return 3'(k);
    if (k == K_ORI) return 3'b011;
    if (k == K_BEQ || k == K_BNE) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] kind_pcsrc(input int k, input logic z);
    if (k == K_BEQ) return z ? 2'b01 : 2'b00;
    if (k == K_BNE) return z ? 2'b00 : 2'b01;
    if (k == K_J || k == K_JAL) return 2'b11;
    if (k == K_JR) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs the first lim cycles of an instruction starting in IF; a full run ends back in IF.
  task automatic run_instr(input int k, input logic z, input int lim);
    int  n;
    logic last, wr;
    n = kind_len(k);
    bus.opcode = kind_op(k);
    bus.funct  = kind_fn(k, 6'($urandom_range(0, 63)));
    bus.zero   = z;
    for (int i = 0; i < lim; i++) begin
      if (i > 0) tick();
      last = (i == n - 1);
      wr   = last && kind_writes(k);
      chk($sformatf("k%0d c%0d state", k, i), 32'(bus.state), 32'(kind_state(k, i)));
      chk($sformatf("k%0d c%0d IRWre", k, i), 32'(bus.IRWre), 32'(i == 0));
      chk($sformatf("k%0d c%0d PCWre", k, i), 32'(bus.PCWre), 32'(last));
      chk($sformatf("k%0d c%0d PCSrc", k, i), 32'(bus.PCSrc),
          32'(last ? kind_pcsrc(k, z) : 2'b00));
      chk($sformatf("k%0d c%0d RegWre", k, i), 32'(bus.RegWre), 32'(wr));
      chk($sformatf("k%0d c%0d mRD", k, i), 32'(bus.mRD), 32'(k == K_LW && i == 3));
      chk($sformatf("k%0d c%0d mWR", k, i), 32'(bus.mWR), 32'(k == K_SW && i == 3));
      if (wr) begin
        chk($sformatf("k%0d RegDst", k), 32'(bus.RegDst), 32'(kind_regdst(k)));
        chk($sformatf("k%0d WrRegDSrc", k), 32'(bus.WrRegDSrc), 32'(k != K_JAL));
        if (k == K_LW) chk("lw DBDataSrc", 32'(bus.DBDataSrc), 32'd1);
      end
      if (i >= 2) begin
        chk($sformatf("k%0d c%0d ALUOp", k, i), 32'(bus.ALUOp), 32'(kind_aluop(k)));
        chk($sformatf("k%0d c%0d ALUSrcB", k, i), 32'(bus.ALUSrcB),
            32'(k >= K_ADDI && k <= K_SW));
        chk($sformatf("k%0d c%0d ExtSel", k, i), 32'(bus.ExtSel), 32'(k != K_ORI));
      end
    end
    if (lim == n) tick();
  endtask

  task automatic chk_quiet(input string tag, input logic irw);
    chk({tag, " IRWre"}, 32'(bus.IRWre), 32'(irw));
    chk({tag, " PCWre"}, 32'(bus.PCWre), 32'd0);
    chk({tag, " RegWre"}, 32'(bus.RegWre), 32'd0);
    chk({tag, " mRD"}, 32'(bus.mRD), 32'd0);
    chk({tag, " mWR"}, 32'(bus.mWR), 32'd0);
    chk({tag, " PCSrc"}, 32'(bus.PCSrc), 32'd0);
    chk({tag, " ALUOp"}, 32'(bus.ALUOp), 32'd0);
  endtask

  initial begin
    int k;
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.zero   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset state", 32'(bus.state), 32'd0);
    chk_quiet("reset", 1'b1);
    Reset = 1'b0;

    run_instr(K_ADD, 1'b0, kind_len(K_ADD));
    run_instr(K_BEQ, 1'b1, kind_len(K_BEQ));
    run_instr(K_BEQ, 1'b0, kind_len(K_BEQ));
    run_instr(K_BNE, 1'b0, kind_len(K_BNE));
    run_instr(K_BNE, 1'b1, kind_len(K_BNE));
    run_instr(K_LW, 1'b0, kind_len(K_LW));
    run_instr(K_SW, 1'b0, kind_len(K_SW));
    run_instr(K_JAL, 1'b0, kind_len(K_JAL));
    run_instr(K_JR, 1'b0, kind_len(K_JR));
    run_instr(K_ORI, 1'b0, kind_len(K_ORI));
    run_instr(K_BADOP, 1'b0, kind_len(K_BADOP));
    run_instr(K_BADFN, 1'b0, kind_len(K_BADFN));

    // Reset arriving while a load sits in MEM abandons it.
    run_instr(K_LW, 1'b0, 4);
    Reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("midlw reset state", 32'(bus.state), 32'd0);
      chk_quiet("midlw reset", 1'b1);
    end
    Reset = 1'b0;
    run_instr(K_SUB_DUMMY(), 1'b0, kind_len(1));

    // Halt opcode parks in ID with everything idle until reset.
    bus.opcode = 6'b111111;
    bus.funct  = 6'b0;
    chk("halt fetch state", 32'(bus.state), 32'd0);
    tick();
    for (int h = 0; h < 20; h++) begin
      chk("halt state", 32'(bus.state), 32'd1);
      chk_quiet("halt", 1'b0);
      tick();
    end
    Reset = 1'b1;
    tick();
    chk("halt reset state", 32'(bus.state), 32'd0);
    chk("halt reset IRWre", 32'(bus.IRWre), 32'd1);
    Reset = 1'b0;
    run_instr(K_ADD, 1'b0, kind_len(K_ADD));

    for (int r = 0; r < 60; r++) begin
      k = int'($urandom_range(0, 15));
      run_instr(k, 1'($urandom_range(0, 1)), kind_len(k));
    end
    chk("final state", 32'(bus.state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int K_SUB_DUMMY();
    return 1;
  endfunction

endmodule
